// File: rtl/wb_load_store.sv
// Load/store unit: builds lane selects, runs one Wishbone B4 classic cycle, extends load data.
// Latency: accept T0, strobe T1, done one cycle after ack/err; illegal requests complete at T1 without a bus cycle.
module wb_load_store #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 30,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [2:0]            funct3_i,
   input  logic [XLEN-1:0]       addr_i,
   input  logic [XLEN-1:0]       wdata_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [XLEN-1:0]       rdata_o,
   output logic [3:0]            sel_o,
   output logic [XLEN-1:0]       unencoded_o,
   input  logic [XLEN-1:0]       decoded_i,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [3:0]            wb_sel_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_err;
   logic                  w_err_nxt;
   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [3:0]            r_sel;
   logic [XLEN-1:0]       r_wdata;
   logic [XLEN-1:0]       r_rdata;
   logic [7:0]            r_cnt;

   logic                  w_accept;
   logic                  w_illegal;
   logic [3:0]            w_sel;
   logic [XLEN-1:0]       w_wdata;
   logic [XLEN-1:0]       w_ext;
   logic                  w_timeout;

   assign w_accept  = (r_state == S_IDLE) && req_i;
   assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

   // Lane select, alignment/legality check and size-masked store data.
   always_comb begin
      w_sel     = 4'b0000;
      w_illegal = 1'b0;
      w_wdata   = wdata_i;
      case (funct3_i)
         3'b000, 3'b100: begin
            w_sel   = 4'b0001 << addr_i[1:0];
            w_wdata = {{(XLEN-8){1'b0}}, wdata_i[7:0]};
         end
         3'b001, 3'b101: begin
            w_sel     = addr_i[1] ? 4'b1100 : 4'b0011;
            w_illegal = addr_i[0];
            w_wdata   = {{(XLEN-16){1'b0}}, wdata_i[15:0]};
         end
         3'b010: begin
            w_sel     = 4'b1111;
            w_illegal = (addr_i[1:0] != 2'b00);
         end
         default: w_illegal = 1'b1;
      endcase
      if (we_i && funct3_i[2]) begin
         w_illegal = 1'b1;
      end
   end

   always_comb begin
      w_ext = decoded_i;
      case (r_funct3)
         3'b000:  w_ext = {{(XLEN-8){decoded_i[7]}}, decoded_i[7:0]};
         3'b001:  w_ext = {{(XLEN-16){decoded_i[15]}}, decoded_i[15:0]};
         3'b100:  w_ext = {{(XLEN-8){1'b0}}, decoded_i[7:0]};
         3'b101:  w_ext = {{(XLEN-16){1'b0}}, decoded_i[15:0]};
         default: w_ext = decoded_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_err_nxt;
      end
   end

   // Bus error takes priority over a simultaneous acknowledge.
   always_comb begin
      w_next    = r_state;
      w_err_nxt = r_err;
      case (r_state)
         S_IDLE: begin
            if (req_i) begin
               w_next    = w_illegal ? S_DONE : S_BUS;
               w_err_nxt = w_illegal;
            end
         end
         S_BUS: begin
            if (wb_err_i) begin
               w_next    = S_DONE;
               w_err_nxt = 1'b1;
            end else if (wb_ack_i) begin
               w_next    = S_DONE;
               w_err_nxt = 1'b0;
            end else if (w_timeout) begin
               w_next    = S_DONE;
               w_err_nxt = 1'b1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_adr    <= '0;
         r_sel    <= 4'b0000;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_cnt    <= 8'd0;
      end else begin
         if (w_accept) begin
            r_we     <= we_i;
            r_funct3 <= funct3_i;
            r_adr    <= addr_i[ADDR_WIDTH+1:2];
            r_sel    <= w_sel;
            r_wdata  <= w_wdata;
            r_cnt    <= 8'd0;
         end else if (r_state == S_BUS) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if ((r_state == S_BUS) && !wb_err_i && wb_ack_i && !r_we) begin
            r_rdata <= w_ext;
         end
      end
   end

   assign ready_o     = (r_state == S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign err_o       = (r_state == S_DONE) && r_err;
   assign rdata_o     = r_rdata;
   assign sel_o       = r_sel;
   assign unencoded_o = r_wdata;
   assign wb_cyc_o    = (r_state == S_BUS);
   assign wb_stb_o    = (r_state == S_BUS);
   assign wb_we_o     = r_we;
   assign wb_adr_o    = r_adr;
   assign wb_sel_o    = r_sel;

endmodule

// File: tb/tb_wb_load_store.sv
// Directed bench for wb_load_store with a short timeout so the abort path is reachable.
module tb_wb_load_store;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [2:0]  funct3_i = 3'b000;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        ready_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic [3:0]  sel_o;
   logic [31:0] unencoded_o;
   logic [31:0] decoded_i = '0;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [29:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   wb_load_store #(.XLEN(32), .ADDR_WIDTH(30), .TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
      .rdata_o(rdata_o), .sel_o(sel_o), .unencoded_o(unencoded_o), .decoded_i(decoded_i),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a request across one rising edge; returns at the falling edge of T1.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      req_i    = 1'b1;
      we_i     = we;
      funct3_i = f3;
      addr_i   = a;
      wdata_i  = wd;
      @(negedge clk_i);
      req_i = 1'b0;
   endtask

   // Ack (or error) during T1, then check the done cycle and return to idle.
   task automatic respond(input string tag, input logic ack, input logic er, input logic [31:0] dat,
                          input logic exp_err, input logic [31:0] exp_rdata);
      wb_ack_i  = ack;
      wb_err_i  = er;
      decoded_i = dat;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_err"}, 32'(err_o), 32'(exp_err));
      check({tag, "_cyc_drop"}, 32'(wb_cyc_o), 32'd0);
      check({tag, "_rdata"}, rdata_o, exp_rdata);
      @(negedge clk_i);
      check({tag, "_ready"}, 32'(ready_o), 32'd1);
      check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
   endtask

   task automatic illegal(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp_rdata);
      issue(we, f3, a, 32'h0);
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_err"}, 32'(err_o), 32'd1);
      check({tag, "_nocyc"}, 32'(wb_cyc_o), 32'd0);
      check({tag, "_rdata"}, rdata_o, exp_rdata);
      @(negedge clk_i);
      check({tag, "_ready"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      @(negedge clk_i);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_cyc", 32'(wb_cyc_o), 32'd0);
      check("rst_stb", 32'(wb_stb_o), 32'd0);
      check("rst_rdata", rdata_o, 32'h0);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // LW 0x100
      issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
      check("lw_cyc", 32'(wb_cyc_o), 32'd1);
      check("lw_stb", 32'(wb_stb_o), 32'd1);
      check("lw_adr", 32'(wb_adr_o), 32'h40);
      check("lw_sel", 32'(wb_sel_o), 32'hF);
      check("lw_we", 32'(wb_we_o), 32'd0);
      check("lw_ready", 32'(ready_o), 32'd0);
      respond("lw", 1'b1, 1'b0, 32'h8000_00F0, 1'b0, 32'h8000_00F0);

      // LB / LBU 0x103
      issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
      check("lb_sel", 32'(sel_o), 32'h8);
      respond("lb", 1'b1, 1'b0, 32'h0000_0080, 1'b0, 32'hFFFF_FF80);
      issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
      respond("lbu", 1'b1, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0080);

      // LH / LHU 0x102
      issue(1'b0, 3'b001, 32'h0000_0102, 32'h0);
      check("lh_sel", 32'(sel_o), 32'hC);
      respond("lh", 1'b1, 1'b0, 32'h0000_8001, 1'b0, 32'hFFFF_8001);
      issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
      respond("lhu", 1'b1, 1'b0, 32'h0000_8001, 1'b0, 32'h0000_8001);

      // SH 0x102, ack cycle presents junk decoder data that must not reach rdata
      issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234);
      check("sh_sel", 32'(wb_sel_o), 32'hC);
      check("sh_we", 32'(wb_we_o), 32'd1);
      check("sh_adr", 32'(wb_adr_o), 32'h40);
      check("sh_data", unencoded_o, 32'h0000_1234);
      respond("sh", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_8001);

      // SB 0x101 lane steering
      issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
      check("sb_sel", 32'(sel_o), 32'h2);
      check("sb_data", unencoded_o, 32'h0000_00A5);
      respond("sb", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_8001);

      // Illegal requests
      illegal("lh_mis", 1'b0, 3'b001, 32'h0000_0101, 32'h0000_8001);
      illegal("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0000_8001);
      illegal("sbu", 1'b1, 3'b100, 32'h0000_0100, 32'h0000_8001);
      illegal("f3_011", 1'b0, 3'b011, 32'h0000_0100, 32'h0000_8001);

      // Timeout: strobe held for 4 cycles, then done with error
      issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_stb%0d", i), 32'(wb_stb_o), 32'd1);
         check($sformatf("to_nodone%0d", i), 32'(done_o), 32'd0);
         @(negedge clk_i);
      end
      check("to_done", 32'(done_o), 32'd1);
      check("to_err", 32'(err_o), 32'd1);
      check("to_stb_drop", 32'(wb_stb_o), 32'd0);
      check("to_rdata", rdata_o, 32'h0000_8001);
      @(negedge clk_i);

      // ack and err together: error wins, rdata untouched
      issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
      respond("ackerr", 1'b1, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_8001);

      // Request while busy is dropped
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      req_i = 1'b1; addr_i = 32'h0000_0400;
      respond("busyreq", 1'b1, 1'b0, 32'h1111_2222, 1'b0, 32'h1111_2222);
      req_i = 1'b0;
      check("busyreq_idle", 32'(wb_cyc_o), 32'd0);

      // Reset during BUS, then ack in idle is ignored
      issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
      #1 rst_n_i = 1'b0;
      #1;
      check("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
      check("rst_mid_stb", 32'(wb_stb_o), 32'd0);
      check("rst_mid_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      wb_ack_i = 1'b1;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      check("rst_nodone", 32'(done_o), 32'd0);
      check("idle_ack_cyc", 32'(wb_cyc_o), 32'd0);
      check("idle_ack_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      check("idle_ack_nodone", 32'(done_o), 32'd0);
      check("rst_rdata_clr", rdata_o, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
